// File: rtl/i2c_init_sequencer_if.sv
`default_nettype none
// ============================================================================
// i2c_init_sequencer_if : AXI-lite bus between the init sequencer and the
//                         i2c_master_axil register slave.
// Revision 1.0 : initial release
// ============================================================================
interface i2c_init_sequencer_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/i2c_init_sequencer.sv
`default_nettype none
// ============================================================================
// i2c_init_sequencer : walks a ROM table of WRITE/POLL/WAIT/END entries and
//                      issues them as AXI-lite transactions.
// Revision 1.0 : initial release
// ============================================================================
module i2c_init_sequencer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ROM_AW     = 6,
  parameter int POLL_LIMIT = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                error,
  output logic [1:0]                          err_code,
  output logic [ROM_AW-1:0]                   err_index,
  output logic [ROM_AW-1:0]                   rom_addr,
  input  logic [2+ADDR_WIDTH+2*DATA_WIDTH-1:0] rom_data,
  i2c_init_sequencer_if.master                m_axil
);

  localparam int ENTRY_W = 2 + ADDR_WIDTH + 2*DATA_WIDTH;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_POLL  = 2'd1;
  localparam logic [1:0] OP_WAIT  = 2'd2;
  localparam logic [1:0] OP_END   = 2'd3;

  localparam logic [1:0] ERR_BRESP = 2'd1;
  localparam logic [1:0] ERR_RRESP = 2'd2;
  localparam logic [1:0] ERR_POLL  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_WR_REQ  = 4'd3,
    S_WR_RESP = 4'd4,
    S_RD_REQ  = 4'd5,
    S_RD_RESP = 4'd6,
    S_DELAY   = 4'd7,
    S_ERROR   = 4'd8
  } state_t;

  state_t                  state_q,     state_d;
  logic [ROM_AW-1:0]       rom_addr_q,  rom_addr_d;
  logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
  logic [DATA_WIDTH-1:0]   value_q,     value_d;
  logic [DATA_WIDTH-1:0]   mask_q,      mask_d;
  logic [DATA_WIDTH-1:0]   cnt_q,       cnt_d;
  logic                    aw_pend_q,   aw_pend_d;
  logic                    w_pend_q,    w_pend_d;
  logic                    done_q,      done_d;
  logic                    error_q,     error_d;
  logic [1:0]              err_code_q,  err_code_d;
  logic [1:0]              code_q,      code_d;
  logic [ROM_AW-1:0]       err_index_q, err_index_d;

  // Entry layout is {op, addr, value, mask}, mask in the low bits.
  logic [1:0]              w_op;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_value;
  logic [DATA_WIDTH-1:0]   w_mask;
  logic [ROM_AW-1:0]       w_next_addr;
  logic                    w_aw_done;
  logic                    w_w_done;
  logic                    w_poll_match;
  logic [DATA_WIDTH-1:0]   w_cnt_inc;

  assign w_op    = rom_data[ENTRY_W-1 -: 2];
  assign w_addr  = rom_data[2*DATA_WIDTH +: ADDR_WIDTH];
  assign w_value = rom_data[DATA_WIDTH +: DATA_WIDTH];
  assign w_mask  = rom_data[0 +: DATA_WIDTH];

  assign w_next_addr  = rom_addr_q + ROM_AW'(1);
  assign w_aw_done    = !aw_pend_q || m_axil.awready;
  assign w_w_done     = !w_pend_q  || m_axil.wready;
  assign w_poll_match = ((m_axil.rdata ^ value_q) & mask_q) == '0;
  assign w_cnt_inc    = cnt_q + DATA_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      addr_q      <= '0;
      value_q     <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 2'd0;
      code_q      <= 2'd0;
      err_index_q <= '0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      addr_q      <= addr_d;
      value_q     <= value_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      code_q      <= code_d;
      err_index_q <= err_index_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    addr_d      = addr_q;
    value_d     = value_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    aw_pend_d   = aw_pend_q;
    w_pend_d    = w_pend_q;
    done_d      = 1'b0;
    error_d     = error_q;
    err_code_d  = err_code_q;
    code_d      = code_q;
    err_index_d = err_index_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rom_addr_d = '0;
          error_d    = 1'b0;
          err_code_d = 2'd0;
          state_d    = S_FETCH;
        end
      end

      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        addr_d  = w_addr;
        value_d = w_value;
        mask_d  = w_mask;
        case (w_op)
          OP_WRITE: begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = S_WR_REQ;
          end
          OP_POLL: begin
            cnt_d   = '0;
            state_d = S_RD_REQ;
          end
          OP_WAIT: begin
            cnt_d   = w_value;
            state_d = S_DELAY;
          end
          OP_END: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end

      // AW and W complete independently; leave only once both have.
      S_WR_REQ: begin
        if (m_axil.awready) aw_pend_d = 1'b0;
        if (m_axil.wready)  w_pend_d  = 1'b0;
        if (w_aw_done && w_w_done) state_d = S_WR_RESP;
      end

      S_WR_RESP: begin
        if (m_axil.bvalid) begin
          if (m_axil.bresp != 2'b00) begin
            code_d  = ERR_BRESP;
            state_d = S_ERROR;
          end else begin
            rom_addr_d = w_next_addr;
            state_d    = S_FETCH;
          end
        end
      end

      S_RD_REQ: begin
        if (m_axil.arready) state_d = S_RD_RESP;
      end

      S_RD_RESP: begin
        if (m_axil.rvalid) begin
          if (m_axil.rresp != 2'b00) begin
            code_d  = ERR_RRESP;
            state_d = S_ERROR;
          end else if (w_poll_match) begin
            rom_addr_d = w_next_addr;
            state_d    = S_FETCH;
          end else if (w_cnt_inc == DATA_WIDTH'(POLL_LIMIT)) begin
            code_d  = ERR_POLL;
            state_d = S_ERROR;
          end else begin
            cnt_d   = w_cnt_inc;
            state_d = S_RD_REQ;
          end
        end
      end

      // A loaded count of 0 or 1 both spend exactly one cycle here.
      S_DELAY: begin
        if (cnt_q <= DATA_WIDTH'(1)) begin
          rom_addr_d = w_next_addr;
          state_d    = S_FETCH;
        end else begin
          cnt_d = cnt_q - DATA_WIDTH'(1);
        end
      end

      S_ERROR: begin
        error_d     = 1'b1;
        err_code_d  = code_q;
        err_index_d = rom_addr_q;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;
  assign err_index = err_index_q;
  assign rom_addr  = rom_addr_q;

  assign m_axil.awaddr  = addr_q;
  assign m_axil.awprot  = 3'b000;
  assign m_axil.awvalid = aw_pend_q;
  assign m_axil.wdata   = value_q;
  assign m_axil.wstrb   = '1;
  assign m_axil.wvalid  = w_pend_q;
  assign m_axil.bready  = (state_q == S_WR_RESP);
  assign m_axil.araddr  = addr_q;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = (state_q == S_RD_REQ);
  assign m_axil.rready  = (state_q == S_RD_RESP);

endmodule
`default_nettype wire

// File: tb/tb_i2c_init_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_i2c_init_sequencer : directed bench with a behavioural ROM and AXI-lite
//                         slave; expected values are hand-derived cycle counts.
// Revision 1.0 : initial release
// ============================================================================
module tb_i2c_init_sequencer;

  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int RAW = 6;
  localparam int EW  = 2 + AW + 2*DW;
  localparam int PL  = 4;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, done, error;
  logic [1:0]     err_code;
  logic [RAW-1:0] err_index, rom_addr;
  logic [EW-1:0]  rom_data;

  always #5 clk = ~clk;

  i2c_init_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  i2c_init_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_AW(RAW), .POLL_LIMIT(PL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .err_index(err_index),
    .rom_addr(rom_addr), .rom_data(rom_data), .m_axil(bus)
  );

  logic [EW-1:0] rom [0:63];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // slave configuration (written only by the stimulus process)
  int          aw_wait, w_wait, bad_b_idx, rd_len;
  logic [31:0] rd_vals [0:7];

  // slave state and monitors (cleared by rst)
  int          aw_ctr, w_ctr, aw_cnt, w_cnt, b_issue, b_cnt, ar_cnt, rd_idx;
  int          aw_hi, w_hi;
  logic        aw_seen, w_seen;
  logic [3:0]  aw_log [0:7];
  logic [31:0] w_log  [0:7];
  logic [3:0]  wstrb_log, araddr_log;
  logic [2:0]  prot_log;

  assign bus.awready = bus.awvalid && (aw_ctr >= aw_wait);
  assign bus.wready  = bus.wvalid  && (w_ctr  >= w_wait);
  assign bus.arready = bus.arvalid;
  assign bus.rresp   = 2'b00;

  always @(posedge clk) begin : slave
    logic a_hs, w_hs, a_now, w_now;
    int   ri;
    a_hs = bus.awvalid && bus.awready;
    w_hs = bus.wvalid && bus.wready;
    if (rst) begin
      aw_ctr <= 0; w_ctr <= 0; aw_cnt <= 0; w_cnt <= 0; b_issue <= 0;
      b_cnt <= 0; ar_cnt <= 0; rd_idx <= 0; aw_hi <= 0; w_hi <= 0;
      aw_seen <= 1'b0; w_seen <= 1'b0; wstrb_log <= 4'h0; araddr_log <= 4'h0;
      prot_log <= 3'b000;
      bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
      bus.rvalid <= 1'b0; bus.rdata <= '0;
    end else begin
      aw_ctr <= (bus.awvalid && !a_hs) ? aw_ctr + 1 : 0;
      w_ctr  <= (bus.wvalid && !w_hs) ? w_ctr + 1 : 0;
      if (bus.awvalid) aw_hi <= aw_hi + 1;
      if (bus.wvalid)  w_hi  <= w_hi + 1;
      if (a_hs) begin
        aw_log[aw_cnt[2:0]] <= bus.awaddr;
        prot_log <= bus.awprot | bus.arprot;
        aw_cnt <= aw_cnt + 1;
      end
      if (w_hs) begin
        w_log[w_cnt[2:0]] <= bus.wdata;
        wstrb_log <= bus.wstrb;
        w_cnt <= w_cnt + 1;
      end
      a_now = aw_seen | a_hs;
      w_now = w_seen | w_hs;
      if (bus.bvalid && bus.bready) begin
        bus.bvalid <= 1'b0;
        b_cnt <= b_cnt + 1;
      end
      if (a_now && w_now && !bus.bvalid) begin
        bus.bvalid <= 1'b1;
        bus.bresp  <= (b_issue == bad_b_idx) ? 2'b10 : 2'b00;
        b_issue <= b_issue + 1;
        aw_seen <= 1'b0;
        w_seen  <= 1'b0;
      end else begin
        aw_seen <= a_now;
        w_seen  <= w_now;
      end
      if (bus.arvalid && bus.arready) begin
        ri = (rd_idx < rd_len) ? rd_idx : rd_len - 1;
        bus.rvalid <= 1'b1;
        bus.rdata  <= rd_vals[ri];
        araddr_log <= bus.araddr;
        rd_idx <= rd_idx + 1;
        ar_cnt <= ar_cnt + 1;
      end else if (bus.rvalid && bus.rready) begin
        bus.rvalid <= 1'b0;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] ent(input logic [1:0] op, input logic [3:0] a,
                                        input logic [31:0] v, input logic [31:0] m);
    return {op, a, v, m};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = ent(2'd3, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Leaves the bench sampling in the FETCH cycle (cycle 0).
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run(input string tag, input int max, output int k_end,
                     output logic done_end, output int first_aw);
    int k;
    k = 0;
    first_aw = -1;
    while (busy && k < max) begin
      if (bus.awvalid && first_aw < 0) first_aw = k;
      tick();
      k++;
    end
    if (busy) chk({tag, "_timeout"}, 64'd1, 64'd0);
    k_end = k;
    done_end = done;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k_end, first_aw;
    logic d_end;

    rst = 1'b1; start = 1'b0;
    aw_wait = 0; w_wait = 0; bad_b_idx = -1; rd_len = 1;
    for (int i = 0; i < 8; i++) rd_vals[i] = 32'h0;
    clear_rom();

    // ---- reset state
    tick(); tick();
    chk("rst_status", {busy, done, error, err_code}, 0);
    chk("rst_idx", {err_index, rom_addr}, 0);
    chk("rst_valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 0);
    rst = 1'b0;
    tick();

    // ---- write, write, END with a zero-wait slave
    clear_rom();
    rom[0] = ent(2'd0, 4'hC, 32'h0000_00FA, 32'h0);
    rom[1] = ent(2'd0, 4'h8, 32'h0000_0055, 32'h0);
    do_reset();
    pulse_start();
    chk("t1_busy_fetch", busy, 1'b1);
    run("t1", 60, k_end, d_end, first_aw);
    chk("t1_done_cycle", k_end, 10);
    chk("t1_done", d_end, 1'b1);
    chk("t1_first_aw", first_aw, 2);
    chk("t1_aw_cnt", aw_cnt, 2);
    chk("t1_w_cnt", w_cnt, 2);
    chk("t1_addr0", aw_log[0], 4'hC);
    chk("t1_data0", w_log[0], 32'h0000_00FA);
    chk("t1_addr1", aw_log[1], 4'h8);
    chk("t1_data1", w_log[1], 32'h0000_0055);
    chk("t1_wstrb_prot", {wstrb_log, 1'b0, prot_log}, {4'hF, 1'b0, 3'b000});
    chk("t1_error", error, 1'b0);
    tick();
    chk("t1_done_pulse", done, 1'b0);

    // ---- skewed write handshakes
    clear_rom();
    rom[0] = ent(2'd0, 4'h4, 32'h1234_5678, 32'h0);
    aw_wait = 3;
    do_reset();
    pulse_start();
    run("t2", 60, k_end, d_end, first_aw);
    chk("t2_done_cycle", k_end, 9);
    chk("t2_done", d_end, 1'b1);
    chk("t2_aw_hi", aw_hi, 4);
    chk("t2_w_hi", w_hi, 1);
    chk("t2_b_cnt", b_cnt, 1);
    chk("t2_data", {aw_log[0], w_log[0]}, {4'h4, 32'h1234_5678});
    aw_wait = 0;

    // ---- poll that passes on the third read
    clear_rom();
    rom[0] = ent(2'd1, 4'h0, 32'h0, 32'h1);
    rom[1] = ent(2'd0, 4'hC, 32'h0000_00AA, 32'h0);
    rd_vals[0] = 32'h1; rd_vals[1] = 32'h1; rd_vals[2] = 32'h0; rd_len = 3;
    do_reset();
    pulse_start();
    run("t3", 80, k_end, d_end, first_aw);
    chk("t3_done_cycle", k_end, 14);
    chk("t3_done", d_end, 1'b1);
    chk("t3_ar_cnt", ar_cnt, 3);
    chk("t3_araddr", araddr_log, 4'h0);
    chk("t3_aw_cnt", aw_cnt, 1);
    chk("t3_error", error, 1'b0);

    // ---- poll timeout on entry 1
    clear_rom();
    rom[0] = ent(2'd0, 4'h8, 32'h3, 32'h0);
    rom[1] = ent(2'd1, 4'h4, 32'h0, 32'h1);
    rd_vals[0] = 32'h1; rd_len = 1;
    do_reset();
    pulse_start();
    run("t4", 80, k_end, d_end, first_aw);
    chk("t4_end_cycle", k_end, 15);
    chk("t4_ar_cnt", ar_cnt, 4);
    chk("t4_araddr", araddr_log, 4'h4);
    chk("t4_err", {error, err_code}, {1'b1, 2'd3});
    chk("t4_err_index", err_index, 1);
    chk("t4_done", d_end, 1'b0);

    // ---- bad write response on entry 1, then restart
    clear_rom();
    rom[0] = ent(2'd0, 4'h0, 32'h11, 32'h0);
    rom[1] = ent(2'd0, 4'h4, 32'h22, 32'h0);
    bad_b_idx = 1;
    do_reset();
    pulse_start();
    run("t5", 60, k_end, d_end, first_aw);
    chk("t5_end_cycle", k_end, 9);
    chk("t5_err", {error, err_code}, {1'b1, 2'd1});
    chk("t5_err_index", err_index, 1);
    chk("t5_done", d_end, 1'b0);
    pulse_start();
    chk("t5_restart_clear", {busy, error, err_code}, {1'b1, 1'b0, 2'd0});
    run("t5b", 60, k_end, d_end, first_aw);
    chk("t5b_done_cycle", k_end, 10);
    chk("t5b_done", {d_end, error}, {1'b1, 1'b0});
    chk("t5b_b_cnt", b_cnt, 4);
    chk("t5b_rerun_addr", aw_log[2], 4'h0);
    bad_b_idx = -1;

    // ---- WAIT 10, ignored start, reset while awvalid pending
    clear_rom();
    rom[0] = ent(2'd2, 4'h0, 32'd10, 32'h0);
    rom[1] = ent(2'd0, 4'h4, 32'h99, 32'h0);
    aw_wait = 100;
    do_reset();
    pulse_start();
    first_aw = -1;
    for (int k = 0; k < 16; k++) begin
      start = (k == 5);
      if (bus.awvalid && first_aw < 0) first_aw = k;
      tick();
    end
    start = 1'b0;
    chk("t6_first_aw", first_aw, 14);
    chk("t6_pending", {busy, bus.awvalid, bus.wvalid}, {1'b1, 1'b1, 1'b0});
    rst = 1'b1;
    tick();
    chk("t6_rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
    chk("t6_rst_busy", {busy, done, error}, 0);
    rst = 1'b0;
    aw_wait = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
